// File: rtl/ultrasonic_echo_emulator_pkg.sv
// rtl/ultrasonic_echo_emulator_pkg.sv - shared state encodings, ranging constants and echo width rule
package ultrasonic_echo_emulator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TRIG_HIGH = 3'd1,
      ST_HOLDOFF   = 3'd2,
      ST_ECHO      = 3'd3,
      ST_COOLDOWN  = 3'd4
   } us_state_t;

   localparam int DEF_CLKS_PER_US = 50;
   localparam int DEF_TRIG_MIN_US = 10;
   localparam int DEF_HOLDOFF_US  = 200;
   localparam int DEF_US_PER_CM   = 58;
   localparam int DEF_MIN_CM      = 2;
   localparam int DEF_MAX_CM      = 400;
   localparam int DEF_NO_ECHO_US  = 38000;
   localparam int DEF_COOLDOWN_US = 10000;
   localparam int US_W            = 16;

   // Echo width in microseconds for a sampled distance; 9b x 6b product never exceeds 15 bits.
   function automatic logic [US_W-1:0] echo_width_us(
      input logic [8:0]      distance_cm,
      input logic            object_present,
      input logic [US_W-1:0] no_echo_us,
      input logic [8:0]      min_cm,
      input logic [8:0]      max_cm,
      input logic [5:0]      us_per_cm
   );
      logic [8:0]  d;
      logic [14:0] prod;
      if (!object_present || distance_cm > max_cm) begin
         return no_echo_us;
      end
      d    = (distance_cm < min_cm) ? min_cm : distance_cm;
      prod = 15'(d) * 15'(us_per_cm);
      return {1'b0, prod};
   endfunction

endpackage

// File: rtl/ultrasonic_echo_emulator_if.sv
// rtl/ultrasonic_echo_emulator_if.sv - trig/echo link between a ranging controller and the emulated sensor
interface ultrasonic_echo_emulator_if;
   logic       trig;
   logic [8:0] distance_cm;
   logic       object_present;
   logic       echo;
   logic       busy;
   logic       err_short_trig;

   modport master (
      output trig, distance_cm, object_present,
      input  echo, busy, err_short_trig
   );

   modport slave (
      input  trig, distance_cm, object_present,
      output echo, busy, err_short_trig
   );
endinterface

// File: rtl/ultrasonic_echo_emulator_us_tick_gen.sv
// rtl/ultrasonic_echo_emulator_us_tick_gen.sv - microsecond prescaler with restart
// The restart cycle counts as the first clk of the new interval, so tick k lands on clk k*CLKS_PER_US-1.
module us_tick_gen #(
   parameter int CLKS_PER_US = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic us_tick
);
   localparam int CW = (CLKS_PER_US > 2) ? $clog2(CLKS_PER_US) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= CW'(1);
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign us_tick = !restart && (cnt == LAST);
endmodule

// File: rtl/ultrasonic_echo_emulator.sv
// rtl/ultrasonic_echo_emulator.sv - HC-SR04-style responder: trig qualification, hold-off, distance-coded echo
module ultrasonic_echo_emulator
   import ultrasonic_echo_emulator_pkg::*;
#(
   parameter int CLKS_PER_US = DEF_CLKS_PER_US,
   parameter int TRIG_MIN_US = DEF_TRIG_MIN_US,
   parameter int HOLDOFF_US  = DEF_HOLDOFF_US,
   parameter int US_PER_CM   = DEF_US_PER_CM,
   parameter int MIN_CM      = DEF_MIN_CM,
   parameter int MAX_CM      = DEF_MAX_CM,
   parameter int NO_ECHO_US  = DEF_NO_ECHO_US,
   parameter int COOLDOWN_US = DEF_COOLDOWN_US
) (
   input logic                       clk,
   input logic                       rst_n,
   ultrasonic_echo_emulator_if.slave bus
);
   localparam int TRIG_MIN_CLKS = TRIG_MIN_US * CLKS_PER_US;
   localparam int TW            = $clog2(TRIG_MIN_CLKS + 1);
   localparam logic [TW-1:0]   TRIG_SAT      = TW'(TRIG_MIN_CLKS);
   // width_cnt misses the rise-detect cycle, so a trig of exactly TRIG_MIN_CLKS reads one less.
   localparam logic [TW-1:0]   TRIG_ACCEPT   = TW'(TRIG_MIN_CLKS - 1);
   localparam logic [US_W-1:0] HOLDOFF_LAST  = US_W'(HOLDOFF_US - 1);
   localparam logic [US_W-1:0] COOLDOWN_LAST = US_W'(COOLDOWN_US - 1);

   logic [1:0] rst_pipe;
   logic       rst_n_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_pipe <= '0;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b1};
      end
   end

   assign rst_n_i = rst_pipe[1];

   logic trig_s1, trig_s2, trig_d;
   logic trig_rise, trig_fall;

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         trig_s1 <= 1'b0;
         trig_s2 <= 1'b0;
         trig_d  <= 1'b0;
      end else begin
         trig_s1 <= bus.trig;
         trig_s2 <= trig_s1;
         trig_d  <= trig_s2;
      end
   end

   assign trig_rise = trig_s2 & ~trig_d;
   assign trig_fall = ~trig_s2 & trig_d;

   logic restart, us_tick;

   us_tick_gen #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
      .clk     (clk),
      .rst_n   (rst_n_i),
      .restart (restart),
      .us_tick (us_tick)
   );

   us_state_t       state;
   logic [TW-1:0]   width_cnt;
   logic [US_W-1:0] us_cnt;
   logic [US_W-1:0] echo_last;
   logic            echo_q, busy_q, err_q;

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= ST_IDLE;
         width_cnt <= '0;
         us_cnt    <= '0;
         echo_last <= '0;
         restart   <= 1'b0;
         echo_q    <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         restart <= 1'b0;
         err_q   <= 1'b0;
         if (us_tick) begin
            us_cnt <= us_cnt + 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (trig_rise) begin
                  state     <= ST_TRIG_HIGH;
                  width_cnt <= '0;
                  busy_q    <= 1'b1;
                  restart   <= 1'b1;
               end
            end
            ST_TRIG_HIGH: begin
               if (trig_fall) begin
                  restart <= 1'b1;
                  if (width_cnt >= TRIG_ACCEPT) begin
                     state     <= ST_HOLDOFF;
                     us_cnt    <= '0;
                     echo_last <= echo_width_us(bus.distance_cm, bus.object_present,
                                                US_W'(NO_ECHO_US), 9'(MIN_CM), 9'(MAX_CM),
                                                6'(US_PER_CM)) - 1'b1;
                  end else begin
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                     err_q  <= 1'b1;
                  end
               end else if (width_cnt != TRIG_SAT) begin
                  width_cnt <= width_cnt + 1'b1;
               end
            end
            ST_HOLDOFF: begin
               if (us_tick && us_cnt == HOLDOFF_LAST) begin
                  state   <= ST_ECHO;
                  echo_q  <= 1'b1;
                  us_cnt  <= '0;
                  restart <= 1'b1;
               end
            end
            ST_ECHO: begin
               if (us_tick && us_cnt == echo_last) begin
                  state   <= ST_COOLDOWN;
                  echo_q  <= 1'b0;
                  us_cnt  <= '0;
                  restart <= 1'b1;
               end
            end
            ST_COOLDOWN: begin
               if (us_tick && us_cnt == COOLDOWN_LAST) begin
                  state   <= ST_IDLE;
                  busy_q  <= 1'b0;
                  us_cnt  <= '0;
                  restart <= 1'b1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               echo_q <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.echo           = echo_q;
   assign bus.busy           = busy_q;
   assign bus.err_short_trig = err_q;
endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// tb/tb_ultrasonic_echo_emulator.sv - randomized bench checked against a timing-rule reference model
module tb_ultrasonic_echo_emulator;
   localparam int C        = 4;
   localparam int HOLD     = 200;
   localparam int CD       = 100;
   localparam int NOECHO   = 600;   // no-echo width shortened so the long responses stay cheap
   localparam int SYNC_LAT = 3;     // trig change at a negedge -> first output change, in clk
   localparam int TMIN     = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ultrasonic_echo_emulator_if bus ();

   ultrasonic_echo_emulator #(
      .CLKS_PER_US (C),
      .COOLDOWN_US (CD),
      .NO_ECHO_US  (NOECHO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int cyc = 0;
   int n_total = 0, n_bad = 0;
   bit checking = 1'b0;
   int m_echo_lo = 0, m_echo_hi = 0, m_busy_lo = 0, m_busy_hi = 0, m_err = -1;
   int rise_cyc = 0, last_width = 0, pulse_cnt = 0, err_cnt = 0, last_fall = 0;
   logic echo_prev = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input int got, input int want);
      n_total++;
      if (got != want) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, got, want);
      end
   endtask

   function automatic int model_width_us(input int d, input bit p);
      if (!p || d > 400) return NOECHO;
      if (d < 2) return 2 * 58;
      return d * 58;
   endfunction

   always @(negedge clk) begin
      if (bus.echo && !echo_prev) rise_cyc = cyc;
      if (!bus.echo && echo_prev) begin
         last_width = cyc - rise_cyc;
         pulse_cnt++;
      end
      if (bus.err_short_trig) err_cnt++;
      echo_prev = bus.echo;
      if (checking) begin
         check("echo", int'(bus.echo), int'(cyc >= m_echo_lo && cyc < m_echo_hi));
         check("busy", int'(bus.busy), int'(cyc >= m_busy_lo && cyc < m_busy_hi));
         check("err_short_trig", int'(bus.err_short_trig), int'(cyc == m_err));
      end
   end

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
      #1;
   endtask

   // A rise is served only if the responder is idle when the synchronized edge is seen.
   task automatic send_trig(input int w, input int d, input bit p);
      int c0;
      bit acc;
      @(negedge clk);
      bus.distance_cm    = 9'(d);
      bus.object_present = p;
      bus.trig           = 1'b1;
      c0  = cyc;
      acc = (c0 + SYNC_LAT - 1 >= m_busy_hi);
      if (acc) begin
         m_busy_lo = c0 + SYNC_LAT;
         m_busy_hi = 32'h7fff_ffff;
      end
      repeat (w) @(negedge clk);
      bus.trig  = 1'b0;
      last_fall = cyc;
      if (acc) begin
         if (w >= TMIN * C) begin
            m_echo_lo = last_fall + SYNC_LAT + HOLD * C;
            m_echo_hi = m_echo_lo + model_width_us(d, p) * C;
            m_busy_hi = m_echo_hi + CD * C;
         end else begin
            m_err     = last_fall + SYNC_LAT;
            m_busy_hi = m_err;
         end
      end
      repeat (4) @(negedge clk);
      bus.distance_cm    = 9'($urandom_range(0, 511));
      bus.object_present = 1'($urandom);
   endtask

   task automatic served(input string name, input int w, input int d, input bit p, input int want_clk);
      int p0;
      p0 = pulse_cnt;
      send_trig(w, d, p);
      wait_until(m_busy_hi + 2);
      check({name, "_pulses"}, pulse_cnt, p0 + 1);
      check({name, "_width"}, last_width, want_clk);
   endtask

   initial begin
      int p0, e0, w, d;
      bit p;
      bus.trig = 1'b0;
      bus.distance_cm = '0;
      bus.object_present = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_echo", int'(bus.echo), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_err", int'(bus.err_short_trig), 0);
      rst_n = 1'b1;
      checking = 1'b1;
      repeat (4) @(negedge clk);

      served("t1", 12 * C, 10, 1'b1, 580 * C);
      check("t1_delay", rise_cyc - last_fall, SYNC_LAT + 200 * C);

      e0 = err_cnt;
      p0 = pulse_cnt;
      send_trig(5 * C, 10, 1'b1);
      wait_until(last_fall + 8);
      check("t2_err", err_cnt, e0 + 1);
      check("t2_no_echo", pulse_cnt, p0);
      check("t2_busy", int'(bus.busy), 0);
      served("t2_next", 12 * C, 7, 1'b1, 406 * C);

      e0 = err_cnt;
      send_trig(TMIN * C - 1, 3, 1'b1);
      wait_until(last_fall + 8);
      check("min_minus1_err", err_cnt, e0 + 1);
      served("min_exact", TMIN * C, 1, 1'b1, 116 * C);

      served("t3_absent", 12 * C, 50, 1'b0, NOECHO * C);
      served("t4_500", 12 * C, 500, 1'b1, NOECHO * C);
      served("t4_401", 12 * C, 401, 1'b1, NOECHO * C);
      served("t4_0", 12 * C, 0, 1'b1, 116 * C);

      e0 = err_cnt;
      p0 = pulse_cnt;
      send_trig(12 * C, 10, 1'b1);
      wait_until(m_echo_lo + 100);
      send_trig(12 * C, 33, 1'b1);
      wait_until(m_echo_hi + 40);
      send_trig(12 * C, 20, 1'b1);
      wait_until(m_busy_hi - 100);
      send_trig(200, 20, 1'b1);
      wait_until(m_busy_hi + 2);
      check("t5_pulses", pulse_cnt, p0 + 1);
      check("t5_width", last_width, 580 * C);
      check("t5_no_err", err_cnt, e0);
      served("t5_after", 12 * C, 4, 1'b1, 232 * C);

      send_trig(12 * C, 10, 1'b1);
      wait_until(m_echo_lo + 100 * C);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      m_echo_lo = 0; m_echo_hi = 0; m_busy_lo = 0; m_busy_hi = 0; m_err = -1;
      #1;
      check("t6_echo_drop", int'(bus.echo), 0);
      check("t6_busy_drop", int'(bus.busy), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      served("t6_after", 12 * C, 20, 1'b1, 1160 * C);

      for (int i = 0; i < 4; i++) begin
         w = ($urandom_range(0, 3) == 0) ? $urandom_range(2 * C, TMIN * C - 1)
                                         : $urandom_range(TMIN * C, 16 * C);
         d = ($urandom_range(0, 3) == 0) ? $urandom_range(401, 511) : $urandom_range(0, 15);
         p = ($urandom_range(0, 4) != 0);
         send_trig(w, d, p);
         wait_until(m_busy_hi + 2);
      end

      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "watchdog");
   end
endmodule
